led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: walks, ping-pongs or counts on the LEDs, advancing on
// rising edges of a selectable divider tick.
//
//   state    | meaning
//   ST_IDLE  | stopped, LEDs dark, waiting for start
//   ST_RUN   | pattern advances on each step event
//   ST_PAUSE | pattern frozen, start resumes where it left off
module led_sequencer #(
    parameter int LED_W = 8
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             tick_1K,
    input  logic             tick_100,
    input  logic             tick_10,
    input  logic             tick_1,
    input  logic [1:0]       speed_sel,
    input  logic [1:0]       mode_sel,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic [15:0]      step_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [LED_W-1:0] LED_LSB = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};

    state_t           state, state_nxt;
    logic [3:0]       tick_vec, tick_q;
    logic             step_evt;
    logic [1:0]       mode_r, mode_nxt;
    logic             dir, dir_nxt, dir_adv;
    logic [LED_W-1:0] led_nxt, led_adv, led_seed;
    logic [15:0]      cnt_nxt;
    logic             busy_nxt;

    // Each tick keeps its own history so a speed change cannot fake an edge.
    assign tick_vec = {tick_1, tick_10, tick_100, tick_1K};
    assign step_evt = tick_vec[speed_sel] & ~tick_q[speed_sel];

    always_comb begin
        led_seed = '0;
        case (mode_sel)
            2'd0:    led_seed = LED_LSB;
            2'd1:    led_seed = LED_MSB;
            2'd2:    led_seed = LED_LSB;
            default: led_seed = '0;
        endcase
    end

    always_comb begin
        led_adv = led;
        dir_adv = dir;
        case (mode_r)
            2'd0: led_adv = {led[LED_W-2:0], led[LED_W-1]};
            2'd1: led_adv = {led[0], led[LED_W-1:1]};
            2'd2: begin
                // Flip on the step that lands on an end bit, so the end is lit once.
                if (dir == DIR_LEFT) begin
                    led_adv = {led[LED_W-2:0], 1'b0};
                    if (led[LED_W-2]) dir_adv = DIR_RIGHT;
                end else begin
                    led_adv = {1'b0, led[LED_W-1:1]};
                    if (led[1]) dir_adv = DIR_LEFT;
                end
            end
            default: led_adv = led + LED_LSB;
        endcase
    end

    always_comb begin
        state_nxt = state;
        led_nxt   = led;
        dir_nxt   = dir;
        cnt_nxt   = step_cnt;
        mode_nxt  = mode_r;
        if (clear) begin
            state_nxt = ST_IDLE;
            led_nxt   = '0;
            dir_nxt   = DIR_LEFT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                        mode_nxt  = mode_sel;
                        led_nxt   = led_seed;
                        dir_nxt   = DIR_LEFT;
                        cnt_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    if (pause && !start) begin
                        state_nxt = ST_PAUSE;
                    end else if (step_evt) begin
                        led_nxt = led_adv;
                        dir_nxt = dir_adv;
                        cnt_nxt = step_cnt + 16'd1;
                    end
                end
                ST_PAUSE: begin
                    if (start) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            tick_q   <= '0;
            led      <= '0;
            dir      <= DIR_LEFT;
            step_cnt <= '0;
            mode_r   <= '0;
            busy     <= 1'b0;
        end else begin
            tick_q   <= tick_vec;
            led      <= led_nxt;
            dir      <= dir_nxt;
            step_cnt <= cnt_nxt;
            mode_r   <= mode_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule
